ahb_lite_sram_slave: RTL and testbench

Parametrised AHB-Lite SRAM slave. It is the synthesizable target that the AHB testbench top instantiates behind its interface. It generalises a fixed 32-bit zero-wait memory model in three ways: configurable data width and depth, programmable wait-state insertion, and a two-cycle ERROR response for illegal accesses. It also provides byte-lane writes with write-to-read bypass.

---
 rtl/ahb_lite_sram_slave.sv | 168 ++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: parametrised width/depth, programmable wait states,
// two-cycle ERROR response for illegal accesses, byte-lane writes with
// write-to-read bypass.
module ahb_lite_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hreadyin,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int NB         = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(NB);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    r_dp_valid;   // a legal transfer occupies the data phase
  logic                    r_write;
  logic [IDX_W-1:0]        r_word;
  logic [BYTE_SHIFT-1:0]   r_off;
  logic [2:0]              r_size;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_take;
  logic                    w_legal;
  logic                    w_misalign;
  logic [ADDR_WIDTH-1:0]   w_word_full;
  logic [IDX_W-1:0]        w_word_idx;
  logic                    w_commit;
  logic                    w_bypass;
  logic [NB-1:0]           w_mask;
  logic [DATA_WIDTH-1:0]   w_mem_word;
  logic [DATA_WIDTH-1:0]   w_rd_merged;
  logic                    w_unused;

  // Burst type carries no information for a memory that decodes every beat.
  assign w_unused = ^hburst;

  // Ready/response depend only on state, so reset forces them asynchronously.
  assign w_ready   = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign hreadyout = w_ready;
  assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata    = (r_state == S_IDLE && r_dp_valid && !r_write) ? r_rdata : '0;

  // Address-phase decode and legality.
  assign w_accept    = hsel & hreadyin & htrans[1];
  assign w_take      = w_accept & w_ready;
  assign w_word_full = haddr >> BYTE_SHIFT;
  assign w_word_idx  = w_word_full[IDX_W-1:0];
  assign w_misalign  = |(haddr[2:0] & ((3'b001 << hsize) - 3'b001));
  assign w_legal     = (w_word_full < DEPTH_A) && (hsize <= 3'(BYTE_SHIFT)) && !w_misalign;

  // A pending write commits on the edge its data phase completes.
  assign w_commit   = (r_state == S_IDLE) && r_dp_valid && r_write;
  assign w_bypass   = w_commit && (r_word == w_word_idx);
  assign w_mem_word = r_mem[w_word_idx];

  // Byte-lane enables of the pending transfer from its offset and size.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < NB; b++) begin
      w_mask[b] = (b >= int'(r_off)) && (b < int'(r_off) + (1 << r_size));
    end
  end

  // Read word merged with any write committing on the same edge.
  always_comb begin
    w_rd_merged = w_mem_word;
    for (int b = 0; b < NB; b++) begin
      if (w_bypass && w_mask[b]) w_rd_merged[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_ERR2: begin
        w_state_nxt = S_IDLE;
        if (w_take) begin
          if (!w_legal) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and registered address-phase information.
  always_ff @(posedge hclk or posedge hreset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (hreset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dp_valid <= 1'b0;
      r_write    <= 1'b0;
      r_word     <= '0;
      r_off      <= '0;
      r_size     <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) begin
        r_dp_valid <= w_legal;
        r_write    <= hwrite;
        r_word     <= w_word_idx;
        r_off      <= haddr[BYTE_SHIFT-1:0];
        r_size     <= hsize;
        if (w_legal && !hwrite) r_rdata <= w_rd_merged;
      end else if (r_state == S_IDLE) begin
        r_dp_valid <= 1'b0;
      end
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge hclk) begin
    // NOTE: the array has no reset so it maps onto plain SRAM; contents are
    // undefined after power-up.
    if (w_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mask[b]) r_mem[r_word][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: one zero-wait slave and one three-wait-state slave on a
// shared address/data bus, selected individually by hsel.
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3;
  logic        hresp0, hresp3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 hclk = ~hclk;

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hreadyin(hready0), .hrdata(hrdata0), .hreadyout(hready0), .hresp(hresp0)
  );

  ahb_lite_sram_slave #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hreadyin(hready3), .hrdata(hrdata3), .hreadyout(hready3), .hresp(hresp3)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic s0, input logic s3, input logic [31:0] a,
                            input logic w, input logic [2:0] sz);
    hsel0  = s0;
    hsel3  = s3;
    haddr  = a;
    htrans = 2'd2;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic drive_idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    haddr  = '0;
    htrans = 2'd0;
    hwrite = 1'b0;
    hsize  = 3'd0;
  endtask

  // Zero-wait write on slave 0.
  task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    drive_addr(1'b1, 1'b0, a, 1'b1, sz);
    step();
    drive_idle();
    hwdata = d;
    step();
  endtask

  // Zero-wait word read on slave 0; returns what the data phase showed.
  task automatic rd0(input logic [31:0] a, output logic [31:0] d, output logic rdy, output logic rsp);
    drive_addr(1'b1, 1'b0, a, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge hclk);
    d   = hrdata0;
    rdy = hready0;
    rsp = hresp0;
    step();
  endtask

  // Waits out slave 3's data phase; returns the number of low-ready cycles
  // and the data/response seen in the completing cycle.
  task automatic finish3(output int lows, output logic [31:0] d, output logic rsp,
                         output logic [31:0] d_wait);
    lows   = 0;
    d_wait = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge hclk);
      if (hready3) break;
      if (lows == 0) d_wait = hrdata3;
      lows++;
      step();
    end
    d   = hrdata3;
    rsp = hresp3;
    step();
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    drive_idle();
    hburst = 3'd0;
    hwdata = '0;
    #2;
    vectors++; if (hready0 !== 1'b1) begin miscompares++; $display("FAIL reset_ready0: got %b expected 1", hready0); end
    vectors++; if (hresp0 !== 1'b0) begin miscompares++; $display("FAIL reset_resp0: got %b expected 0", hresp0); end
    vectors++; if (hrdata0 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata0: got %h expected 00000000", hrdata0); end
    vectors++; if (hready3 !== 1'b1) begin miscompares++; $display("FAIL reset_ready3: got %b expected 1", hready3); end
    step();
    step();
    hreset = 1'b0;
    step();
  endtask

  task automatic test_word_rw();
    logic [31:0] d;
    logic r, p;
    wr0(32'h10, 32'hDEADBEEF, 3'd2);
    rd0(32'h10, d, r, p);
    vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_read: got %h expected deadbeef", d); end
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL word_ready: got %b expected 1", r); end
    vectors++; if (p !== 1'b0) begin miscompares++; $display("FAIL word_resp: got %b expected 0", p); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic r, p;
    wr0(32'h20, 32'h11223344, 3'd2);
    wr0(32'h22, 32'h00AA0000, 3'd0);
    rd0(32'h20, d, r, p);
    vectors++; if (d !== 32'h11AA3344) begin miscompares++; $display("FAIL byte_lane2: got %h expected 11aa3344", d); end
    wr0(32'h24, 32'h55667788, 3'd2);
    wr0(32'h26, 32'hBEEF0000, 3'd1);
    rd0(32'h24, d, r, p);
    vectors++; if (d !== 32'hBEEF7788) begin miscompares++; $display("FAIL half_upper: got %h expected beef7788", d); end
    wr0(32'h25, 32'h0000CC00, 3'd0);
    rd0(32'h24, d, r, p);
    vectors++; if (d !== 32'hBEEFCC88) begin miscompares++; $display("FAIL byte_lane1: got %h expected beefcc88", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic r, p;
    drive_addr(1'b1, 1'b0, 32'h40, 1'b1, 3'd2);
    step();
    hwdata = 32'hCAFEF00D;
    drive_addr(1'b1, 1'b0, 32'h40, 1'b0, 3'd2);
    step();
    drive_idle();
    hwdata = '0;
    @(negedge hclk);
    vectors++; if (hrdata0 !== 32'hCAFEF00D) begin miscompares++; $display("FAIL bypass_word: got %h expected cafef00d", hrdata0); end
    vectors++; if (hresp0 !== 1'b0) begin miscompares++; $display("FAIL bypass_resp: got %b expected 0", hresp0); end
    step();
    drive_addr(1'b1, 1'b0, 32'h41, 1'b1, 3'd0);
    step();
    hwdata = 32'h00001200;
    drive_addr(1'b1, 1'b0, 32'h40, 1'b0, 3'd2);
    step();
    drive_idle();
    hwdata = '0;
    @(negedge hclk);
    vectors++; if (hrdata0 !== 32'hCAFE120D) begin miscompares++; $display("FAIL bypass_byte: got %h expected cafe120d", hrdata0); end
    step();
    rd0(32'h40, d, r, p);
    vectors++; if (d !== 32'hCAFE120D) begin miscompares++; $display("FAIL bypass_stored: got %h expected cafe120d", d); end
  endtask

  task automatic test_idle_beats();
    logic [31:0] d;
    logic r, p;
    hsel0  = 1'b1;
    haddr  = 32'h10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'd0;
    step();
    hwdata = 32'h0BAD0BAD;
    htrans = 2'd1;
    @(negedge hclk);
    vectors++; if (hready0 !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b expected 1", hready0); end
    vectors++; if (hrdata0 !== 32'h0) begin miscompares++; $display("FAIL idle_rdata: got %h expected 00000000", hrdata0); end
    step();
    drive_idle();
    step();
    rd0(32'h10, d, r, p);
    vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL idle_nowrite: got %h expected deadbeef", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic r, p;
    logic [31:0] err_addr [3];
    logic [2:0]  err_size [3];
    err_addr[0] = 32'h400; err_size[0] = 3'd2;
    err_addr[1] = 32'h002; err_size[1] = 3'd2;
    err_addr[2] = 32'h000; err_size[2] = 3'd3;
    wr0(32'h000, 32'h01234567, 3'd2);
    for (int k = 0; k < 3; k++) begin
      drive_addr(1'b1, 1'b0, err_addr[k], 1'b1, err_size[k]);
      step();
      drive_idle();
      hwdata = 32'hFFFFFFFF;
      @(negedge hclk);
      vectors++; if ({hresp0, hready0} !== 2'b10) begin miscompares++; $display("FAIL err%0d_cycle1: got resp/ready %b expected 10", k, {hresp0, hready0}); end
      step();
      @(negedge hclk);
      vectors++; if ({hresp0, hready0} !== 2'b11) begin miscompares++; $display("FAIL err%0d_cycle2: got resp/ready %b expected 11", k, {hresp0, hready0}); end
      vectors++; if (hrdata0 !== 32'h0) begin miscompares++; $display("FAIL err%0d_rdata: got %h expected 00000000", k, hrdata0); end
      step();
      @(negedge hclk);
      vectors++; if ({hresp0, hready0} !== 2'b01) begin miscompares++; $display("FAIL err%0d_after: got resp/ready %b expected 01", k, {hresp0, hready0}); end
    end
    rd0(32'h000, d, r, p);
    vectors++; if (d !== 32'h01234567) begin miscompares++; $display("FAIL err_mem_kept: got %h expected 01234567", d); end
    // Illegal read, then a legal read accepted during its second error cycle.
    drive_addr(1'b1, 1'b0, 32'h404, 1'b0, 3'd2);
    step();
    drive_idle();
    step();
    drive_addr(1'b1, 1'b0, 32'h000, 1'b0, 3'd2);
    @(negedge hclk);
    vectors++; if ({hresp0, hready0} !== 2'b11) begin miscompares++; $display("FAIL err_pipe_cycle2: got resp/ready %b expected 11", {hresp0, hready0}); end
    step();
    drive_idle();
    @(negedge hclk);
    vectors++; if (hrdata0 !== 32'h01234567) begin miscompares++; $display("FAIL err_pipe_read: got %h expected 01234567", hrdata0); end
    vectors++; if (hresp0 !== 1'b0) begin miscompares++; $display("FAIL err_pipe_resp: got %b expected 0", hresp0); end
    step();
  endtask

  task automatic test_wait_states();
    int          lows;
    logic [31:0] d, dw;
    logic        p;
    drive_addr(1'b0, 1'b1, 32'h30, 1'b1, 3'd2);
    step();
    drive_idle();
    hwdata = 32'h13579BDF;
    finish3(lows, d, p, dw);
    vectors++; if (lows !== 3) begin miscompares++; $display("FAIL wait_write_lows: got %0d expected 3", lows); end
    drive_addr(1'b0, 1'b1, 32'h30, 1'b0, 3'd2);
    step();
    drive_idle();
    hwdata = '0;
    finish3(lows, d, p, dw);
    vectors++; if (lows !== 3) begin miscompares++; $display("FAIL wait_read_lows: got %0d expected 3", lows); end
    vectors++; if (d !== 32'h13579BDF) begin miscompares++; $display("FAIL wait_read_data: got %h expected 13579bdf", d); end
    vectors++; if (dw !== 32'h0) begin miscompares++; $display("FAIL wait_rdata_hidden: got %h expected 00000000", dw); end
    vectors++; if (p !== 1'b0) begin miscompares++; $display("FAIL wait_read_resp: got %b expected 0", p); end
    // Errors on the wait-state slave still take exactly two cycles.
    drive_addr(1'b0, 1'b1, 32'h400, 1'b0, 3'd2);
    step();
    drive_idle();
    @(negedge hclk);
    vectors++; if ({hresp3, hready3} !== 2'b10) begin miscompares++; $display("FAIL wait_err_cycle1: got resp/ready %b expected 10", {hresp3, hready3}); end
    step();
    @(negedge hclk);
    vectors++; if ({hresp3, hready3} !== 2'b11) begin miscompares++; $display("FAIL wait_err_cycle2: got resp/ready %b expected 11", {hresp3, hready3}); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int          lows;
    logic [31:0] d, dw;
    logic        p;
    drive_addr(1'b0, 1'b1, 32'h30, 1'b1, 3'd2);
    step();
    drive_idle();
    hwdata = 32'hFFFFFFFF;
    step();
    vectors++; if (hready3 !== 1'b0) begin miscompares++; $display("FAIL rst_pre_wait: got %b expected 0", hready3); end
    #2;
    hreset = 1'b1;
    #1;
    vectors++; if (hready3 !== 1'b1) begin miscompares++; $display("FAIL rst_async_ready: got %b expected 1", hready3); end
    vectors++; if (hresp3 !== 1'b0) begin miscompares++; $display("FAIL rst_async_resp: got %b expected 0", hresp3); end
    step();
    @(negedge hclk);
    hreset = 1'b0;
    hwdata = '0;
    step();
    drive_addr(1'b0, 1'b1, 32'h30, 1'b0, 3'd2);
    step();
    drive_idle();
    finish3(lows, d, p, dw);
    vectors++; if (d !== 32'h13579BDF) begin miscompares++; $display("FAIL rst_write_dropped: got %h expected 13579bdf", d); end
    vectors++; if (lows !== 3) begin miscompares++; $display("FAIL rst_read_lows: got %0d expected 3", lows); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_back_to_back();
    test_idle_beats();
    test_errors();
    test_wait_states();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
